// File: rtl/key_scan_pkg.sv
// Shared definitions for the 74HC165 key scanner: scan phase encoding and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package key_scan_pkg;

  typedef enum logic [2:0] {
    GAP    = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SHIFT  = 3'd3,
    EVAL   = 3'd4
  } scan_state_t;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hc165_shifter.sv
// 74HC165 timing engine: parallel load, settle, then shift N_BITS MSB-first into raw.
// Latency: (2*N_BITS+1)*CLK_DIV cycles from start to done; pins are registered.
// Backpressure: none; start is ignored while a scan is in progress.
module hc165_shifter
  import key_scan_pkg::*;
#(
  parameter int N_BITS  = 16,
  parameter int CLK_DIV = 25
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              ser_dat,
  output logic              hc165_pl,
  output logic              hc165_clk,
  output logic              done,
  output logic [N_BITS-1:0] raw
);

  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam int BIT_W = cnt_w(N_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);

  scan_state_t       state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              hi_q, hi_d;
  logic [N_BITS-1:0] raw_q, raw_d;
  logic              div_end;

  assign div_end = (div_q == DIV_LAST);
  // raw carries the completed vector (including the final bit) in the done cycle.
  assign raw     = raw_d;

  // Phase sequencing; bits enter at the LSB so the first bit out lands in raw[N_BITS-1].
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    raw_d   = raw_q;
    done    = 1'b0;
    case (state_q)
      GAP: begin
        if (start) begin
          state_d = LOAD;
          div_d   = '0;
        end
      end
      LOAD: begin
        if (div_end) begin
          state_d = SETTLE;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SETTLE: begin
        if (div_end) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
          hi_d    = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (hi_q) begin
            hi_d  = 1'b0;
            bit_d = bit_q + 1'b1;
          end else begin
            raw_d = {raw_q[N_BITS-2:0], ser_dat};
            if (bit_q == BIT_LAST) begin
              // Last bit: no trailing high phase, so the chain sees N_BITS-1 rising edges.
              done    = 1'b1;
              state_d = GAP;
            end else begin
              hi_d = 1'b1;
            end
          end
        end
      end
      default: state_d = GAP;
    endcase
  end

  // State, counters, sample register and pin drivers decoded from the next state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= GAP;
      div_q     <= '0;
      bit_q     <= '0;
      hi_q      <= 1'b0;
      raw_q     <= '0;
      hc165_pl  <= 1'b1;
      hc165_clk <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      hi_q      <= hi_d;
      raw_q     <= raw_d;
      hc165_pl  <= (state_d != LOAD);
      hc165_clk <= (state_d == SHIFT) && hi_d;
    end
  end

endmodule

// File: rtl/key_scan_hc165.sv
// Free-running 74HC165 chain scanner with per-bit debounce and change flag.
// Latency: keys updates in the EVAL cycle of the DEBOUNCE-th identical scan.
// Backpressure: none; key_valid/scan_done are single-cycle pulses, never held.
module key_scan_hc165
  import key_scan_pkg::*;
#(
  parameter int N_BITS   = 16,
  parameter int CLK_DIV  = 25,
  parameter int SCAN_GAP = 50000,
  parameter int DEBOUNCE = 3,
  parameter int ACT_LOW  = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  output logic              hc165_pl,
  output logic              hc165_clk,
  input  logic              hc165_dat,
  output logic [N_BITS-1:0] keys,
  output logic              key_valid,
  output logic              scan_done
);

  localparam int GAP_W = cnt_w(SCAN_GAP);
  localparam int CNT_W = cnt_w(DEBOUNCE + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(SCAN_GAP - 1);
  localparam logic [CNT_W-1:0]  DEB_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [N_BITS-1:0] INV_MASK = (ACT_LOW != 0) ? {N_BITS{1'b1}} : {N_BITS{1'b0}};

  // Top only distinguishes idle gap, engine busy (SHIFT) and evaluation.
  scan_state_t       state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_BITS-1:0] prev_q, prev_d;
  logic [N_BITS-1:0] v;
  logic              start, upd;
  logic              dat_meta, dat_sync;
  logic              sh_done;
  logic [N_BITS-1:0] sh_raw;

  hc165_shifter #(
    .N_BITS  (N_BITS),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .ser_dat   (dat_sync),
    .hc165_pl  (hc165_pl),
    .hc165_clk (hc165_clk),
    .done      (sh_done),
    .raw       (sh_raw)
  );

  // Two-flop synchronizer for the asynchronous chain output.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dat_meta <= 1'b0;
      dat_sync <= 1'b0;
    end else begin
      dat_meta <= hc165_dat;
      dat_sync <= dat_meta;
    end
  end

  // Scan sequencing plus debounce decision, evaluated on the engine's done cycle.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    start   = 1'b0;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    upd     = 1'b0;
    v       = sh_raw ^ INV_MASK;
    case (state_q)
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          start   = 1'b1;
          state_d = SHIFT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      SHIFT:   if (sh_done) state_d = EVAL;
      EVAL:    state_d = GAP;
      default: state_d = GAP;
    endcase
    if (sh_done) begin
      if (v == prev_q) begin
        cnt_d = (cnt_q >= DEB_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d  = CNT_W'(1);
        prev_d = v;
      end
      upd = (cnt_d >= DEB_MAX) && (v != keys);
    end
  end

  // Registered state and outputs; pulses are high exactly during the EVAL cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= GAP;
      gap_q     <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      keys      <= '0;
      key_valid <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      scan_done <= sh_done;
      key_valid <= upd;
      if (upd) keys <= v;
    end
  end

endmodule

// File: tb/tb_key_scan_hc165.sv
// Directed bench: two chained 74HC165 models feed the scanner; checks debounce, timing, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_scan_hc165;

  localparam int N_BITS   = 16;
  localparam int CLK_DIV  = 3;
  localparam int SCAN_GAP = 20;
  localparam int PERIOD   = SCAN_GAP + 33 * CLK_DIV + 1;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b1;
  logic              hc165_pl, hc165_clk, hc165_dat;
  logic [N_BITS-1:0] keys;
  logic              key_valid, scan_done;

  logic [15:0] din = 16'hFFFF;
  logic [7:0]  sr0 = 8'hFF;  // device whose Q7 drives hc165_dat
  logic [7:0]  sr1 = 8'hFF;  // upstream device, feeds sr0 serial input

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, pl_low = 0, rises = 0, kv_total = 0, kv_stray = 0;
  logic clk_prev = 1'b0;

  key_scan_hc165 #(
    .N_BITS   (N_BITS),
    .CLK_DIV  (CLK_DIV),
    .SCAN_GAP (SCAN_GAP),
    .DEBOUNCE (3),
    .ACT_LOW  (1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .hc165_pl  (hc165_pl),
    .hc165_clk (hc165_clk),
    .hc165_dat (hc165_dat),
    .keys      (keys),
    .key_valid (key_valid),
    .scan_done (scan_done)
  );

  always #5 sys_clk = ~sys_clk;

  // 74HC165 pair: async parallel load while /PL low, rising-edge shift otherwise.
  always @(posedge hc165_clk or negedge hc165_pl) begin
    if (!hc165_pl) begin
      sr0 <= din[15:8];
      sr1 <= din[7:0];
    end else begin
      sr0 <= {sr0[6:0], sr1[7]};
      sr1 <= {sr1[6:0], 1'b0};
    end
  end
  assign hc165_dat = sr0[7];

  // Free-running event counters; the stimulus block only takes differences.
  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    if (!hc165_pl) pl_low = pl_low + 1;
    if (hc165_clk && !clk_prev) rises = rises + 1;
    clk_prev = hc165_clk;
    if (key_valid) kv_total = kv_total + 1;
    if (key_valid && !scan_done) kv_stray = kv_stray + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Returns at the negedge inside the next EVAL cycle (scan_done high).
  task automatic wait_scan();
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!scan_done && n < 4 * PERIOD);
    chk("scan_timeout", {31'd0, scan_done}, 32'd1);
  endtask

  initial begin
    int kv0, t0, pl0, r0, c0, r, n;
    logic prev;

    #1 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_pl", {31'd0, hc165_pl}, 32'd1);
    chk("rst_clk", {31'd0, hc165_clk}, 32'd0);
    chk("rst_keys", {16'd0, keys}, 32'd0);
    chk("rst_kv", {31'd0, key_valid}, 32'd0);
    chk("rst_sd", {31'd0, scan_done}, 32'd0);
    sys_rst_n = 1'b1;

    // Idle chain: all released.
    kv0 = kv_total;
    repeat (10) wait_scan();
    chk("idle_keys", {16'd0, keys}, 32'd0);
    chk("idle_kv", kv_total - kv0, 32'd0);

    // Two-scan glitch on bit 15 must be filtered.
    kv0 = kv_total;
    din = 16'h7FFF;
    repeat (2) wait_scan();
    din = 16'hFFFF;
    repeat (4) wait_scan();
    chk("glitch_keys", {16'd0, keys}, 32'd0);
    chk("glitch_kv", kv_total - kv0, 32'd0);

    // Bit 0 pressed: accepted on the third scan.
    kv0 = kv_total;
    din = 16'hFFFE;
    repeat (2) wait_scan();
    chk("deb_keys_early", {16'd0, keys}, 32'd0);
    wait_scan();
    chk("deb_kv_pulse", {31'd0, key_valid}, 32'd1);
    chk("deb_keys", {16'd0, keys}, 32'h0001);
    @(negedge sys_clk);
    chk("deb_kv_width", {31'd0, key_valid}, 32'd0);
    chk("sd_width", {31'd0, scan_done}, 32'd0);
    repeat (3) wait_scan();
    chk("deb_kv_once", kv_total - kv0, 32'd1);

    // Pin timing over one full scan.
    t0  = cyc;
    pl0 = pl_low;
    r0  = rises;
    wait_scan();
    chk("scan_period", cyc - t0, PERIOD);
    chk("pl_low_cycles", pl_low - pl0, CLK_DIV);
    chk("clk_rises", rises - r0, 32'd15);

    // Asymmetric pattern checks bit order.
    din = 16'hA55A;
    repeat (2) wait_scan();
    chk("pat_keys_early", {16'd0, keys}, 32'h0001);
    wait_scan();
    chk("pat_kv", {31'd0, key_valid}, 32'd1);
    chk("pat_keys", {16'd0, keys}, 32'h5AA5);
    chk("pat_msb_nibble", {28'd0, keys[15:12]}, 32'h5);
    chk("pat_lsb", {31'd0, keys[0]}, 32'd1);

    // Reset during the high phase of bit 7.
    wait_scan();
    r = 0;
    n = 0;
    prev = hc165_clk;
    while (r < 8 && n < 4 * PERIOD) begin
      @(negedge sys_clk);
      n++;
      if (hc165_clk && !prev) r++;
      prev = hc165_clk;
    end
    chk("pre_rst_clk", {31'd0, hc165_clk}, 32'd1);
    chk("pre_rst_keys", {16'd0, keys}, 32'h5AA5);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_pl", {31'd0, hc165_pl}, 32'd1);
    chk("mid_rst_clk", {31'd0, hc165_clk}, 32'd0);
    chk("mid_rst_keys", {16'd0, keys}, 32'd0);
    chk("mid_rst_kv", {31'd0, key_valid}, 32'd0);
    repeat (2) @(negedge sys_clk);
    din = 16'h0FF0;
    sys_rst_n = 1'b1;
    c0  = cyc;
    kv0 = kv_total;
    wait_scan();
    chk("post_rst_latency", cyc - c0, SCAN_GAP + 33 * CLK_DIV);
    chk("post_rst_keys1", {16'd0, keys}, 32'd0);
    repeat (2) wait_scan();
    chk("post_rst_kv", {31'd0, key_valid}, 32'd1);
    chk("post_rst_keys", {16'd0, keys}, 32'hF00F);
    @(negedge sys_clk);
    chk("post_rst_kv_count", kv_total - kv0, 32'd1);
    chk("kv_outside_eval", kv_stray, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
